// File: rtl/pdi_pkg.sv
// Shared types and helpers for the PDI bearing/ship transmit link.
// State encodings, default channel widths and the binary-to-Gray helper.
package pdi_pkg;

  localparam int BEAR_W = 12;
  localparam int SHIP_W = 8;

  typedef enum logic [1:0] {
    PDI_ST_IDLE  = 2'd0,
    PDI_ST_SHIFT = 2'd1,
    PDI_ST_DONE  = 2'd2
  } pdi_st_e;

  // Sized at 32 bits so any channel width can cast in and out of it.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pdi_tx_chan.sv
// One PDI transmit channel: input sync, edge detect, frame FSM, shift register and bit counter.
// The word to send arrives on load_val and is captured on each latch rising edge.
module pdi_tx_chan
  import pdi_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] load_val,
  input  logic         pdi_clk,
  input  logic         pdi_lt,
  input  logic         clr_err,
  output logic         dat,
  output logic         frame_done,
  output logic         over_clk
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [SYNC_STAGES-1:0] clk_sync, lt_sync;
  logic                   clk_d, lt_d;
  logic                   rise, fall;
  pdi_st_e                state, state_nxt;
  logic [W-1:0]           sr;
  logic [CW-1:0]          cnt;
  logic                   shift_en, done_set, over_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '0;
      lt_sync  <= '0;
      clk_d    <= 1'b0;
      lt_d     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], pdi_clk};
      lt_sync  <= {lt_sync[SYNC_STAGES-2:0], pdi_lt};
      clk_d    <= clk_sync[SYNC_STAGES-1];
      lt_d     <= lt_sync[SYNC_STAGES-1];
    end
  end

  assign rise = lt_sync[SYNC_STAGES-1] & ~lt_d;
  assign fall = ~clk_sync[SYNC_STAGES-1] & clk_d;

  always_ff @(posedge clk) begin
    if (reset) state <= PDI_ST_IDLE;
    else       state <= state_nxt;
  end

  // A latch edge always restarts the frame and swallows a coincident clock fall.
  always_comb begin
    state_nxt = state;
    case (state)
      PDI_ST_IDLE:  if (rise) state_nxt = PDI_ST_SHIFT;
      PDI_ST_SHIFT: if (rise) state_nxt = PDI_ST_SHIFT;
                    else if (fall && cnt == '0) state_nxt = PDI_ST_DONE;
      PDI_ST_DONE:  if (rise) state_nxt = PDI_ST_SHIFT;
      default:      state_nxt = PDI_ST_IDLE;
    endcase
  end

  always_comb begin
    dat      = 1'b0;
    shift_en = 1'b0;
    done_set = 1'b0;
    over_set = 1'b0;
    case (state)
      PDI_ST_SHIFT: begin
        dat      = sr[W-1];
        shift_en = fall && !rise && cnt != '0;
        done_set = fall && !rise && cnt == '0;
      end
      PDI_ST_DONE:  over_set = fall && !rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr         <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      over_clk   <= 1'b0;
    end else begin
      if (rise) begin
        sr  <= load_val;
        cnt <= CW'(W - 1);
      end else if (shift_en) begin
        sr  <= {sr[W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
      end
      frame_done <= done_set;
      over_clk   <= over_set | (over_clk & ~clr_err);
    end
  end

endmodule

// File: rtl/pdi_bear_ship_tx.sv
// Two-channel PDI transmitter: bearing (ch0) and ship (ch1) holding registers feeding two channels.
// Define PDI_GRAY_EN to Gray-code the bearing word on its load path; holding regs stay binary.
module pdi_bear_ship_tx #(
  parameter int BEAR_W      = pdi_pkg::BEAR_W,
  parameter int SHIP_W      = pdi_pkg::SHIP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [BEAR_W-1:0] BearIn,
  input  logic              BearWe,
  input  logic [SHIP_W-1:0] ShipIn,
  input  logic              ShipWe,
  input  logic [1:0]        PdiClk,
  input  logic [1:0]        PdiLt,
  output logic [1:0]        PdiDat,
  output logic [1:0]        FrameDone,
  output logic [1:0]        OverClk,
  input  logic              ClrErr
);
  import pdi_pkg::*;

  logic [BEAR_W-1:0] bear_hold, bear_load;
  logic [SHIP_W-1:0] ship_hold;

  // Channels sample the hold value at the load edge, so a same-cycle write lands in the next frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bear_hold <= '0;
      ship_hold <= '0;
    end else begin
      if (BearWe) bear_hold <= BearIn;
      if (ShipWe) ship_hold <= ShipIn;
    end
  end

`ifdef PDI_GRAY_EN
  assign bear_load = BEAR_W'(bin2gray(32'(bear_hold)));
`else
  assign bear_load = bear_hold;
`endif

  pdi_tx_chan #(.W(BEAR_W), .SYNC_STAGES(SYNC_STAGES)) u_ch0 (
    .clk        (Clk),
    .reset      (Reset),
    .load_val   (bear_load),
    .pdi_clk    (PdiClk[0]),
    .pdi_lt     (PdiLt[0]),
    .clr_err    (ClrErr),
    .dat        (PdiDat[0]),
    .frame_done (FrameDone[0]),
    .over_clk   (OverClk[0])
  );

  pdi_tx_chan #(.W(SHIP_W), .SYNC_STAGES(SYNC_STAGES)) u_ch1 (
    .clk        (Clk),
    .reset      (Reset),
    .load_val   (ship_hold),
    .pdi_clk    (PdiClk[1]),
    .pdi_lt     (PdiLt[1]),
    .clr_err    (ClrErr),
    .dat        (PdiDat[1]),
    .frame_done (FrameDone[1]),
    .over_clk   (OverClk[1])
  );

endmodule

// File: tb/tb_pdi_bear_ship_tx.sv
// Directed bench for pdi_bear_ship_tx: frames on both channels, overclock, restart and collision cases.
// Expected words are hand-computed constants; Gray variants are chosen when PDI_GRAY_EN is defined.
module tb_pdi_bear_ship_tx;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [11:0] BearIn;
  logic        BearWe;
  logic [7:0]  ShipIn;
  logic        ShipWe;
  logic [1:0]  PdiClk, PdiLt, PdiDat, FrameDone, OverClk;
  logic        ClrErr;

  int checks = 0;
  int errors = 0;
  int fd0 = 0;
  int fd1 = 0;

  pdi_bear_ship_tx #(.BEAR_W(12), .SHIP_W(8), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .BearIn(BearIn), .BearWe(BearWe),
    .ShipIn(ShipIn), .ShipWe(ShipWe), .PdiClk(PdiClk), .PdiLt(PdiLt),
    .PdiDat(PdiDat), .FrameDone(FrameDone), .OverClk(OverClk), .ClrErr(ClrErr)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (!Reset && FrameDone[0]) fd0 <= fd0 + 1;
    if (!Reset && FrameDone[1]) fd1 <= fd1 + 1;
  end

`ifdef PDI_GRAY_EN
  localparam logic [11:0] EXP_A5C = 12'hF72;
  localparam logic [4:0]  EXP_FFF5 = 5'b10000;
  localparam logic [11:0] EXP_5A3 = 12'h772;
  localparam logic [11:0] EXP_0F0 = 12'h088;
`else
  localparam logic [11:0] EXP_A5C = 12'hA5C;
  localparam logic [4:0]  EXP_FFF5 = 5'b11111;
  localparam logic [11:0] EXP_5A3 = 12'h5A3;
  localparam logic [11:0] EXP_0F0 = 12'h0F0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic lt_pulse(input int ch);
    PdiLt[ch] = 1'b1; cyc(6);
    PdiLt[ch] = 1'b0; cyc(6);
  endtask

  task automatic clk_fall(input int ch);
    PdiClk[ch] = 1'b0; cyc(6);
    PdiClk[ch] = 1'b1; cyc(6);
  endtask

  // Sample the current bit (what the receiver sees on its rising edge), then issue the fall.
  task automatic shift_bits(input int ch, input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bits = {bits[30:0], PdiDat[ch]};
      clk_fall(ch);
    end
  endtask

  task automatic wr_bear(input logic [11:0] v);
    BearIn = v; BearWe = 1'b1; cyc(1); BearWe = 1'b0;
  endtask

  logic [31:0] bits;
  int          f0;

  initial begin
    Reset = 1'b1; BearIn = '0; BearWe = 0; ShipIn = '0; ShipWe = 0;
    PdiClk = 2'b11; PdiLt = 2'b00; ClrErr = 0;

    // Reset held while pins toggle
    for (int i = 0; i < 3; i++) begin
      PdiClk = ~PdiClk; PdiLt = ~PdiLt;
      cyc(1);
      chk("rst_dat", PdiDat, 2'b00);
      chk("rst_fd", FrameDone, 2'b00);
      chk("rst_ovc", OverClk, 2'b00);
    end
    PdiClk = 2'b11; PdiLt = 2'b00;
    cyc(1);
    Reset = 1'b0;
    cyc(8);
    chk("idle_dat", PdiDat, 2'b00);
    chk("idle_ovc", OverClk, 2'b00);

    // Bearing frame
    wr_bear(12'hA5C);
    lt_pulse(0);
    shift_bits(0, 12, bits);
    chk("ch0_frame", bits[11:0], EXP_A5C);
    chk("ch0_fd", fd0, 1);
    chk("ch0_dat_after", PdiDat[0], 1'b0);
    chk("ch0_ovc", OverClk[0], 1'b0);

    // Ship frame with two extra clocks
    ShipIn = 8'h3C; ShipWe = 1'b1; cyc(1); ShipWe = 1'b0;
    lt_pulse(1);
    shift_bits(1, 8, bits);
    chk("ch1_frame", bits[7:0], 8'h3C);
    chk("ch1_fd", fd1, 1);
    chk("ch1_ovc_pre", OverClk[1], 1'b0);
    clk_fall(1);
    chk("ch1_ovc_9", OverClk[1], 1'b1);
    clk_fall(1);
    chk("ch1_ovc_10", OverClk[1], 1'b1);
    chk("ch1_fd_once", fd1, 1);
    chk("ch0_ovc_indep", OverClk[0], 1'b0);
    ClrErr = 1'b1; cyc(1); ClrErr = 1'b0; cyc(1);
    chk("ch1_ovc_clr", OverClk[1], 1'b0);

    // Mid-frame restart
    wr_bear(12'hFFF);
    lt_pulse(0);
    f0 = fd0;
    shift_bits(0, 5, bits);
    chk("abort_5bits", bits[4:0], EXP_FFF5);
    wr_bear(12'h001);
    lt_pulse(0);
    chk("abort_no_fd", fd0, f0);
    shift_bits(0, 12, bits);
    chk("reload_frame", bits[11:0], 12'h001);
    chk("reload_fd", fd0, f0 + 1);
    chk("reload_ovc", OverClk[0], 1'b0);

    // Latch and clock fall together, with a write landing on the load cycle
    wr_bear(12'h5A3);
    cyc(2);
    f0 = fd0;
    PdiLt[0] = 1'b1; PdiClk[0] = 1'b0;
    cyc(2);
    BearIn = 12'h0F0; BearWe = 1'b1; cyc(1); BearWe = 1'b0;
    cyc(3);
    chk("coll_ovc", OverClk[0], 1'b0);
    chk("coll_msb", PdiDat[0], EXP_5A3[11]);
    PdiLt[0] = 1'b0; PdiClk[0] = 1'b1; cyc(6);
    shift_bits(0, 12, bits);
    chk("coll_old_word", bits[11:0], EXP_5A3);
    chk("coll_fd", fd0, f0 + 1);
    lt_pulse(0);
    shift_bits(0, 12, bits);
    chk("coll_new_word", bits[11:0], EXP_0F0);
    chk("coll_fd2", fd0, f0 + 2);
    chk("end_ovc", OverClk, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
